// File: rtl/ex_mem_buffer_if.sv
// Handshake and data bundle between the execute stage, the EX/MEM buffer and the memory stage.
// The slave modport is the buffer side and the master modport is the driving/consuming side.
interface ex_mem_buffer_if #(
    parameter int WIDTH = 12,
    parameter int RW    = 4
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [2*WIDTH-1:0]   alu_out;
    logic                 alu_n;
    logic                 alu_z;
    logic                 alu_v;
    logic                 alu_c;
    logic [RW-1:0]        rd_in;
    logic                 reg_we_in;
    logic                 set_flags;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result_out;
    logic [RW-1:0]        rd_out;
    logic                 reg_we_out;
    logic [3:0]           flags_out;

    modport slave (
        input  in_valid, alu_out, alu_n, alu_z, alu_v, alu_c, rd_in, reg_we_in,
               set_flags, flush, out_ready,
        output in_ready, out_valid, result_out, rd_out, reg_we_out, flags_out
    );

    modport master (
        output in_valid, alu_out, alu_n, alu_z, alu_v, alu_c, rd_in, reg_we_in,
               set_flags, flush, out_ready,
        input  in_ready, out_valid, result_out, rd_out, reg_we_out, flags_out
    );
endinterface

// File: rtl/ex_mem_buffer.sv
// Two-entry EX/MEM skid buffer: head drives the memory stage and skid absorbs one result
// under backpressure, so in_ready depends only on registered state.
module ex_mem_buffer #(
    parameter int WIDTH = 12,
    parameter int RW    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ex_mem_buffer_if.slave       bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [2*WIDTH-1:0]   r_head_result;
    logic [RW-1:0]        r_head_rd;
    logic                 r_head_we;
    logic [2*WIDTH-1:0]   r_skid_result;
    logic [RW-1:0]        r_skid_rd;
    logic                 r_skid_we;
    logic [3:0]           r_flags;

    logic                 w_accept;
    logic                 w_pop;

    assign w_accept = bus.in_valid & r_in_ready  & ~bus.flush;
    assign w_pop    = r_out_valid  & bus.out_ready & ~bus.flush;

    // Handshake outputs are registered copies of the occupancy, updated alongside r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= EMPTY;
            r_in_ready    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_head_result <= '0;
            r_head_rd     <= '0;
            r_head_we     <= 1'b0;
            r_skid_result <= '0;
            r_skid_rd     <= '0;
            r_skid_we     <= 1'b0;
            r_flags       <= '0;
        end else begin
            if (w_accept && bus.set_flags) begin
                r_flags <= {bus.alu_n, bus.alu_z, bus.alu_v, bus.alu_c};
            end
            if (bus.flush) begin
                r_state     <= EMPTY;
                r_out_valid <= 1'b0;
                r_in_ready  <= 1'b1;
            end else begin
                case (r_state)
                    EMPTY: begin
                        r_in_ready <= 1'b1;
                        if (w_accept) begin
                            r_head_result <= bus.alu_out;
                            r_head_rd     <= bus.rd_in;
                            r_head_we     <= bus.reg_we_in;
                            r_state       <= ONE;
                            r_out_valid   <= 1'b1;
                        end
                    end
                    ONE: begin
                        if (w_accept && w_pop) begin
                            r_head_result <= bus.alu_out;
                            r_head_rd     <= bus.rd_in;
                            r_head_we     <= bus.reg_we_in;
                        end else if (w_accept) begin
                            r_skid_result <= bus.alu_out;
                            r_skid_rd     <= bus.rd_in;
                            r_skid_we     <= bus.reg_we_in;
                            r_state       <= TWO;
                            r_in_ready    <= 1'b0;
                        end else if (w_pop) begin
                            r_state     <= EMPTY;
                            r_out_valid <= 1'b0;
                        end
                    end
                    TWO: begin
                        if (w_pop) begin
                            r_head_result <= r_skid_result;
                            r_head_rd     <= r_skid_rd;
                            r_head_we     <= r_skid_we;
                            r_state       <= ONE;
                            r_in_ready    <= 1'b1;
                        end
                    end
                    default: begin
                        r_state     <= EMPTY;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.result_out = r_head_result;
    assign bus.rd_out     = r_head_rd;
    assign bus.reg_we_out = r_head_we;
    assign bus.flags_out  = r_flags;
endmodule

// File: tb/tb_ex_mem_buffer.sv
// Bench for ex_mem_buffer: a queue-based model of the two-entry buffer is checked every
// falling edge, alongside directed scenarios with hand-computed expectations.
module tb_ex_mem_buffer;
    localparam int WIDTH = 12;
    localparam int RW    = 4;

    typedef struct packed {
        logic [2*WIDTH-1:0] d;
        logic [RW-1:0]      rd;
        logic               we;
    } ent_t;

    logic clk;
    logic rst_n;

    ex_mem_buffer_if #(.WIDTH(WIDTH), .RW(RW)) bus ();

    ex_mem_buffer #(.WIDTH(WIDTH), .RW(RW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    ent_t m_q[$];
    logic [3:0] m_flags;
    bit   m_started;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_flags   = 4'b0000;
        m_started = 1'b0;
    endfunction

    // Behavioural view: a FIFO of at most two results, ready once any edge follows reset.
    function automatic void model_step();
        bit   rdy;
        bit   vld;
        bit   acc;
        bit   pop;
        ent_t e;
        rdy = m_started && (m_q.size() < 2);
        vld = (m_q.size() > 0);
        acc = bus.in_valid && rdy && !bus.flush;
        pop = vld && bus.out_ready && !bus.flush;
        if (acc && bus.set_flags) m_flags = {bus.alu_n, bus.alu_z, bus.alu_v, bus.alu_c};
        if (bus.flush) begin
            m_q.delete();
        end else begin
            if (pop) void'(m_q.pop_front());
            if (acc) begin
                e.d  = bus.alu_out;
                e.rd = bus.rd_in;
                e.we = bus.reg_we_in;
                m_q.push_back(e);
            end
        end
        m_started = 1'b1;
    endfunction

    always @(negedge clk) begin
        chk("out_valid", 32'(bus.out_valid), 32'(m_q.size() > 0));
        chk("in_ready",  32'(bus.in_ready),  32'(m_started && (m_q.size() < 2)));
        chk("flags_out", 32'(bus.flags_out), 32'(m_flags));
        if (m_q.size() > 0) begin
            chk("result_out", 32'(bus.result_out), 32'(m_q[0].d));
            chk("rd_out",     32'(bus.rd_out),     32'(m_q[0].rd));
            chk("reg_we_out", 32'(bus.reg_we_out), 32'(m_q[0].we));
        end
    end

    task automatic drive(input bit v, input logic [2*WIDTH-1:0] d, input logic [RW-1:0] rd,
                         input bit we, input bit sf, input logic [3:0] f, input bit ordy,
                         input bit fl);
        bus.in_valid  = v;
        bus.alu_out   = d;
        bus.rd_in     = rd;
        bus.reg_we_in = we;
        bus.set_flags = sf;
        {bus.alu_n, bus.alu_z, bus.alu_v, bus.alu_c} = f;
        bus.out_ready = ordy;
        bus.flush     = fl;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input bit ordy);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 4'b0000, ordy, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        model_reset();
        bus.in_valid = 1'b0; bus.alu_out = '0; bus.rd_in = '0; bus.reg_we_in = 1'b0;
        bus.set_flags = 1'b0; bus.alu_n = 1'b0; bus.alu_z = 1'b0; bus.alu_v = 1'b0;
        bus.alu_c = 1'b0; bus.out_ready = 1'b0; bus.flush = 1'b0;
        #3;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        chk("rst_flags",     32'(bus.flags_out), 32'd0);
        chk("rst_result",    32'(bus.result_out), 32'd0);
        chk("rst_rd",        32'(bus.rd_out),    32'd0);
        chk("rst_we",        32'(bus.reg_we_out), 32'd0);
        #9 rst_n = 1'b1;
        #1 chk("post_rst_ready_before_edge", 32'(bus.in_ready), 32'd0);
        idle(1'b1);
        chk("post_rst_ready_after_edge", 32'(bus.in_ready), 32'd1);

        // Single pass
        drive(1'b1, 24'h000ABC, 4'd3, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0);
        chk("pass_valid", 32'(bus.out_valid), 32'd1);
        chk("pass_result", 32'(bus.result_out), 32'h000ABC);
        chk("pass_rd", 32'(bus.rd_out), 32'd3);
        chk("pass_flags", 32'(bus.flags_out), 32'd0);
        idle(1'b1);
        chk("pass_empty", 32'(bus.out_valid), 32'd0);

        // Backpressure
        drive(1'b1, 24'd5, 4'd1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        drive(1'b1, 24'd7, 4'd2, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_head", 32'(bus.result_out), 32'd5);
        idle(1'b1);
        chk("bp_second", 32'(bus.result_out), 32'd7);
        chk("bp_ready_again", 32'(bus.in_ready), 32'd1);
        idle(1'b1);
        chk("bp_drained", 32'(bus.out_valid), 32'd0);

        // Flags gating
        drive(1'b1, 24'd1, 4'd1, 1'b0, 1'b1, 4'b1000, 1'b1, 1'b0);
        drive(1'b1, 24'd2, 4'd1, 1'b0, 1'b0, 4'b0101, 1'b1, 1'b0);
        chk("flags_gated", 32'(bus.flags_out), 32'b1000);
        idle(1'b1);

        // Flush with two entries and a same-cycle input
        drive(1'b1, 24'h11, 4'd4, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        drive(1'b1, 24'h22, 4'd5, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        chk("fl_full", 32'(bus.in_ready), 32'd0);
        drive(1'b1, 24'd9, 4'd6, 1'b1, 1'b1, 4'b0100, 1'b1, 1'b1);
        chk("fl_valid", 32'(bus.out_valid), 32'd0);
        chk("fl_flags", 32'(bus.flags_out), 32'b1000);
        idle(1'b1);
        chk("fl_no9_a", 32'(bus.out_valid), 32'd0);
        idle(1'b1);
        chk("fl_no9_b", 32'(bus.out_valid), 32'd0);

        // Full throughput
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 24'(k), 4'(k), 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
            chk("tp_result", 32'(bus.result_out), 32'(k));
            chk("tp_ready", 32'(bus.in_ready), 32'd1);
        end
        idle(1'b1);
        chk("tp_drained", 32'(bus.out_valid), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) < 7), 24'($urandom), 4'($urandom), 1'($urandom),
                  1'($urandom), 4'($urandom), ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset while holding two entries
        drive(1'b0, '0, '0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
        drive(1'b1, 24'h33, 4'd7, 1'b1, 1'b1, 4'b0011, 1'b0, 1'b0);
        drive(1'b1, 24'h44, 4'd8, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        chk("ar_full", 32'(bus.in_ready), 32'd0);
        chk("ar_flags_set", 32'(bus.flags_out), 32'b0011);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("ar_valid", 32'(bus.out_valid), 32'd0);
        chk("ar_flags", 32'(bus.flags_out), 32'd0);
        chk("ar_ready", 32'(bus.in_ready), 32'd0);
        chk("ar_result", 32'(bus.result_out), 32'd0);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("ar_ready_held", 32'(bus.in_ready), 32'd0);
        idle(1'b1);
        chk("ar_ready_back", 32'(bus.in_ready), 32'd1);
        chk("ar_no_old", 32'(bus.out_valid), 32'd0);
        idle(1'b1);
        chk("ar_no_old_b", 32'(bus.out_valid), 32'd0);

        #10;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
